merge_arb_n_cache: RTL and testbench

MERGE_ARB_N_CACHE -- requirements
Module: merge_arb_n_cache

---
 rtl/merge_arb_n_cache.sv | 108 ++++++++++
 tb/tb_merge_arb_n_cache.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_arb_n_cache.sv
// N-channel merging arbiter (fixed-priority or round-robin) feeding a small
// FIFO that tags each accepted beat with its source channel index.
module merge_arb_n_cache #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 5,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 1,
  localparam int SRC_W   = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        i_drive,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  output logic [NUM_CH-1:0]        o_free,
  output logic                     o_driveNext,
  output logic [DATA_W-1:0]        o_data,
  output logic [SRC_W-1:0]         o_src,
  input  logic                     i_freeNext,
  output logic [CNT_W-1:0]         o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = SRC_W + DATA_W;

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [SRC_W-1:0]  arb_ptr;
  logic [SRC_W-1:0]  win_idx;
  logic [DATA_W-1:0] win_data;
  logic              win_valid;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data[k] = i_data[k*DATA_W +: DATA_W];
  end

  // Search starts at arb_ptr in round-robin mode, at channel 0 otherwise.
  always_comb begin : arb
    int unsigned       c;
    logic [NUM_CH-1:0] drv_sh;
    c         = 0;
    drv_sh    = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      c = (ARB_MODE == 1) ? (32'(arb_ptr) + i) : i;
      if (c >= NUM_CH) c = c - NUM_CH;
      drv_sh = i_drive >> c;
      if (!win_valid && drv_sh[0]) begin
        win_valid = 1'b1;
        win_idx   = SRC_W'(c);
      end
    end
  end

  assign win_data = ch_data[win_idx];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

  // Full blocks acceptance regardless of a same-cycle pop, so o_free never
  // depends on i_freeNext.
  always_comb begin
    o_free = '0;
    if (rstn && win_valid && !full) o_free = NUM_CH'(1) << win_idx;
  end

  assign push = |o_free;
  assign pop  = !empty && i_freeNext;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {win_idx, win_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      arb_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && ARB_MODE == 1)
        arb_ptr <= (win_idx == SRC_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Storage is not reset; an empty buffer forces the head outputs to zero.
  assign head        = mem[rd_ptr];
  assign o_driveNext = !empty;
  assign o_data      = empty ? '0 : head[DATA_W-1:0];
  assign o_src       = empty ? '0 : head[ENT_W-1:DATA_W];
  assign o_count     = count;

endmodule

// File: tb/tb_merge_arb_n_cache.sv
// Self-checking bench for merge_arb_n_cache: directed scenarios on small
// configurations plus randomized 8-channel stress against a queue model.
module tb_merge_arb_n_cache;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // a: 2ch RR depth4, b: 4ch fixed depth4, c: 3ch RR depth4,
  // r: 8ch RR depth8, f: 8ch fixed depth2
  logic [1:0]  a_drive, a_free;  logic [9:0]  a_data;  logic a_dn, a_fn;
  logic [4:0]  a_odata; logic [0:0] a_src; logic [2:0] a_cnt;
  logic [3:0]  b_drive, b_free;  logic [19:0] b_data;  logic b_dn, b_fn;
  logic [4:0]  b_odata; logic [1:0] b_src; logic [2:0] b_cnt;
  logic [2:0]  c_drive, c_free;  logic [14:0] c_data;  logic c_dn, c_fn;
  logic [4:0]  c_odata; logic [1:0] c_src; logic [2:0] c_cnt;
  logic [7:0]  r_drive, r_free;  logic [39:0] r_data;  logic r_dn, r_fn;
  logic [4:0]  r_odata; logic [2:0] r_src; logic [3:0] r_cnt;
  logic [7:0]  f_drive, f_free;  logic [39:0] f_data;  logic f_dn, f_fn;
  logic [4:0]  f_odata; logic [2:0] f_src; logic [1:0] f_cnt;

  merge_arb_n_cache #(.NUM_CH(2), .DATA_W(5), .DEPTH(4), .ARB_MODE(1)) u_a (
    .clk(clk), .rstn(rstn), .i_drive(a_drive), .i_data(a_data), .o_free(a_free),
    .o_driveNext(a_dn), .o_data(a_odata), .o_src(a_src), .i_freeNext(a_fn), .o_count(a_cnt));
  merge_arb_n_cache #(.NUM_CH(4), .DATA_W(5), .DEPTH(4), .ARB_MODE(0)) u_b (
    .clk(clk), .rstn(rstn), .i_drive(b_drive), .i_data(b_data), .o_free(b_free),
    .o_driveNext(b_dn), .o_data(b_odata), .o_src(b_src), .i_freeNext(b_fn), .o_count(b_cnt));
  merge_arb_n_cache #(.NUM_CH(3), .DATA_W(5), .DEPTH(4), .ARB_MODE(1)) u_c (
    .clk(clk), .rstn(rstn), .i_drive(c_drive), .i_data(c_data), .o_free(c_free),
    .o_driveNext(c_dn), .o_data(c_odata), .o_src(c_src), .i_freeNext(c_fn), .o_count(c_cnt));
  merge_arb_n_cache #(.NUM_CH(8), .DATA_W(5), .DEPTH(8), .ARB_MODE(1)) u_r (
    .clk(clk), .rstn(rstn), .i_drive(r_drive), .i_data(r_data), .o_free(r_free),
    .o_driveNext(r_dn), .o_data(r_odata), .o_src(r_src), .i_freeNext(r_fn), .o_count(r_cnt));
  merge_arb_n_cache #(.NUM_CH(8), .DATA_W(5), .DEPTH(2), .ARB_MODE(0)) u_f (
    .clk(clk), .rstn(rstn), .i_drive(f_drive), .i_data(f_data), .o_free(f_free),
    .o_driveNext(f_dn), .o_data(f_odata), .o_src(f_src), .i_freeNext(f_fn), .o_count(f_cnt));

  // Reference arbitration: first requesting channel scanning upward from start.
  function automatic int pick(input logic [7:0] drv, input int nch, input int start);
    for (int i = 0; i < nch; i++) begin
      int ch;
      ch = (start + i) % nch;
      if (((drv >> ch) & 8'd1) != 8'd0) return ch;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    a_drive = '0; a_data = '0; a_fn = 1'b0;
    b_drive = '0; b_data = '0; b_fn = 1'b0;
    c_drive = '0; c_data = '0; c_fn = 1'b0;
    r_drive = '0; r_data = '0; r_fn = 1'b0;
    f_drive = '0; f_data = '0; f_fn = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    a_drive = '1; b_drive = '1; r_drive = '1; a_fn = 1'b1;
    #3;
    total++; if (a_free !== 2'b00) begin bad++; $display("FAIL reset_a_free got=%b exp=00", a_free); end
    total++; if (b_free !== 4'b0000) begin bad++; $display("FAIL reset_b_free got=%b exp=0000", b_free); end
    total++; if (r_free !== 8'h00) begin bad++; $display("FAIL reset_r_free got=%b exp=0", r_free); end
    total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL reset_a_cnt got=%0d exp=0", a_cnt); end
    total++; if (a_dn !== 1'b0) begin bad++; $display("FAIL reset_a_dn got=%b exp=0", a_dn); end
    total++; if ({a_src, a_odata} !== 6'd0) begin bad++; $display("FAIL reset_a_head got=%h exp=0", {a_src, a_odata}); end
    total++; if (r_cnt !== 4'd0) begin bad++; $display("FAIL reset_r_cnt got=%0d exp=0", r_cnt); end
    do_reset();
  endtask

  task automatic test_rr_alternate();
    do_reset();
    a_drive = 2'b11; a_data = {5'h15, 5'h0A}; a_fn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] ef;
      @(negedge clk);
      ef = (i % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (a_free !== ef) begin bad++; $display("FAIL rr_free[%0d] got=%b exp=%b", i, a_free, ef); end
      if (i == 0) begin
        total++; if (a_dn !== 1'b0) begin bad++; $display("FAIL rr_latency got=%b exp=0", a_dn); end
      end else begin
        logic [0:0] es;
        logic [4:0] ed;
        es = 1'((i - 1) % 2);
        ed = (es == 1'b1) ? 5'h15 : 5'h0A;
        total++; if (a_src !== es) begin bad++; $display("FAIL rr_src[%0d] got=%0d exp=%0d", i, a_src, es); end
        total++; if (a_odata !== ed) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, a_odata, ed); end
        total++; if (a_cnt !== 3'd1 || a_dn !== 1'b1) begin bad++; $display("FAIL rr_cnt[%0d] got=%0d/%b exp=1/1", i, a_cnt, a_dn); end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    b_drive = 4'hF; b_data = 20'($urandom); b_fn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (b_free !== 4'b0001) begin bad++; $display("FAIL fp_free[%0d] got=%b exp=0001", i, b_free); end
      if (i > 0) begin
        total++; if (b_src !== 2'd0 || b_odata !== b_data[4:0]) begin bad++;
          $display("FAIL fp_head[%0d] got=%0d/%h exp=0/%h", i, b_src, b_odata, b_data[4:0]); end
        total++; if (b_cnt !== 3'd1) begin bad++; $display("FAIL fp_cnt[%0d] got=%0d exp=1", i, b_cnt); end
      end
      @(posedge clk); #1;
    end
    b_drive = 4'b1010;
    @(negedge clk);
    total++; if (b_free !== 4'b0010) begin bad++; $display("FAIL fp_low_idx got=%b exp=0010", b_free); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_full();
    logic [1:0] t_free [6] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [4:0] t_data [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd0};
    logic [2:0] t_cnt  [6] = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    do_reset();
    a_fn = 1'b0; a_drive = 2'b10;
    for (int b = 1; b <= 5; b++) begin
      logic [1:0] ef;
      a_data = {5'(b), 5'h00};
      @(negedge clk);
      ef = (b <= 4) ? 2'b10 : 2'b00;
      total++; if (a_free !== ef) begin bad++; $display("FAIL full_free[%0d] got=%b exp=%b", b, a_free, ef); end
      total++; if (a_cnt !== 3'(b - 1)) begin bad++; $display("FAIL full_cnt[%0d] got=%0d exp=%0d", b, a_cnt, b - 1); end
      if (b >= 2) begin
        total++; if (a_odata !== 5'd1) begin bad++; $display("FAIL full_stall[%0d] got=%h exp=01", b, a_odata); end
      end
      @(posedge clk); #1;
    end
    a_fn = 1'b1;
    for (int j = 0; j < 6; j++) begin
      a_drive = (j <= 1) ? 2'b10 : 2'b00;
      @(negedge clk);
      total++; if (a_free !== t_free[j]) begin bad++; $display("FAIL drain_free[%0d] got=%b exp=%b", j, a_free, t_free[j]); end
      total++; if (a_odata !== t_data[j]) begin bad++; $display("FAIL drain_data[%0d] got=%0d exp=%0d", j, a_odata, t_data[j]); end
      total++; if (a_src !== ((j < 5) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL drain_src[%0d] got=%0d exp=%0d", j, a_src, j < 5); end
      total++; if (a_cnt !== t_cnt[j]) begin bad++; $display("FAIL drain_cnt[%0d] got=%0d exp=%0d", j, a_cnt, t_cnt[j]); end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_rr_wrap();
    logic [2:0] t_drv  [4] = '{3'b010, 3'b101, 3'b101, 3'b101};
    logic [2:0] t_free [4] = '{3'b010, 3'b100, 3'b001, 3'b100};
    logic [1:0] t_src  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [4:0] t_data [4] = '{5'd0, 5'd11, 5'd22, 5'd3};
    do_reset();
    c_fn = 1'b1; c_data = {5'd22, 5'd11, 5'd3};
    for (int s = 0; s < 4; s++) begin
      c_drive = t_drv[s];
      @(negedge clk);
      total++; if (c_free !== t_free[s]) begin bad++; $display("FAIL wrap_free[%0d] got=%b exp=%b", s, c_free, t_free[s]); end
      if (s > 0) begin
        total++; if (c_src !== t_src[s] || c_odata !== t_data[s]) begin bad++;
          $display("FAIL wrap_head[%0d] got=%0d/%0d exp=%0d/%0d", s, c_src, c_odata, t_src[s], t_data[s]); end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_fn = 1'b0; a_drive = 2'b01; a_data = {5'h00, 5'h07};
    repeat (3) begin @(posedge clk); #1; end
    a_drive = 2'b00;
    @(negedge clk);
    total++; if (a_cnt !== 3'd3) begin bad++; $display("FAIL mid_prefill got=%0d exp=3", a_cnt); end
    a_drive = 2'b11;
    #1 rstn = 1'b0;
    #1;
    total++; if (a_cnt !== 3'd0 || a_dn !== 1'b0) begin bad++; $display("FAIL mid_async got=%0d/%b exp=0/0", a_cnt, a_dn); end
    total++; if ({a_src, a_odata} !== 6'd0) begin bad++; $display("FAIL mid_head got=%h exp=0", {a_src, a_odata}); end
    total++; if (a_free !== 2'b00) begin bad++; $display("FAIL mid_free got=%b exp=00", a_free); end
    a_drive = 2'b00;
    #1 rstn = 1'b1;
    a_fn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (a_dn !== 1'b0 || a_cnt !== 3'd0) begin bad++; $display("FAIL mid_stale[%0d] got=%b/%0d exp=0/0", i, a_dn, a_cnt); end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_stress();
    logic [7:0] qr[$];
    logic [7:0] qf[$];
    int ptr_r;
    do_reset();
    ptr_r = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int wr, wf;
      logic [7:0] efr, eff, hr, hf, ent_r, ent_f;
      logic pop_r, pop_f;
      r_drive = 8'($urandom) & 8'($urandom_range(0, 255));
      if (cyc % 50 < 10) r_drive = 8'h00;
      r_data  = {8'($urandom), 32'($urandom)};
      r_fn    = ($urandom_range(0, 99) < ((cyc < 200) ? 30 : 75));
      f_drive = r_drive; f_data = r_data; f_fn = r_fn;
      @(negedge clk);
      wr = pick(r_drive, 8, ptr_r);
      wf = pick(f_drive, 8, 0);
      efr = (qr.size() < 8 && wr >= 0) ? 8'(1 << wr) : 8'h00;
      eff = (qf.size() < 2 && wf >= 0) ? 8'(1 << wf) : 8'h00;
      hr = (qr.size() > 0) ? qr[0] : 8'h00;
      hf = (qf.size() > 0) ? qf[0] : 8'h00;
      total++; if (r_free !== efr || !$onehot0(r_free)) begin bad++; $display("FAIL st_r_free[%0d] got=%b exp=%b", cyc, r_free, efr); end
      total++; if ({r_src, r_odata} !== hr || r_dn !== (qr.size() > 0)) begin bad++;
        $display("FAIL st_r_head[%0d] got=%h/%b exp=%h/%0d", cyc, {r_src, r_odata}, r_dn, hr, qr.size() > 0); end
      total++; if (r_cnt !== 4'(qr.size())) begin bad++; $display("FAIL st_r_cnt[%0d] got=%0d exp=%0d", cyc, r_cnt, qr.size()); end
      total++; if (f_free !== eff || !$onehot0(f_free)) begin bad++; $display("FAIL st_f_free[%0d] got=%b exp=%b", cyc, f_free, eff); end
      total++; if ({f_src, f_odata} !== hf || f_dn !== (qf.size() > 0)) begin bad++;
        $display("FAIL st_f_head[%0d] got=%h/%b exp=%h/%0d", cyc, {f_src, f_odata}, f_dn, hf, qf.size() > 0); end
      total++; if (f_cnt !== 2'(qf.size())) begin bad++; $display("FAIL st_f_cnt[%0d] got=%0d exp=%0d", cyc, f_cnt, qf.size()); end
      pop_r = (qr.size() > 0) && r_fn;
      pop_f = (qf.size() > 0) && f_fn;
      ent_r = (wr >= 0) ? {3'(wr), 5'(r_data >> (wr * 5))} : 8'h00;
      ent_f = (wf >= 0) ? {3'(wf), 5'(f_data >> (wf * 5))} : 8'h00;
      @(posedge clk); #1;
      if (pop_r) void'(qr.pop_front());
      if (pop_f) void'(qf.pop_front());
      if (efr != 8'h00) begin qr.push_back(ent_r); ptr_r = (wr + 1) % 8; end
      if (eff != 8'h00) qf.push_back(ent_f);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_rr_alternate();
    test_fixed_priority();
    test_full();
    test_rr_wrap();
    test_reset_mid();
    test_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
